// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> memory 128-bit block interface.
// Used by block_mem_responder / block_mem_array and the cache's
// memory-side logic.
// Optional feature macro used by importers: MEM_STATS_EN.
package mem_if_pkg;
  localparam int BLOCK_W = 128;
  localparam int BADDR_W = 28;
  localparam int WORD_W  = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  // Responder FSM encoding
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} mem_op_e;

  // Request fields captured at acceptance (index is kept separately,
  // since its width depends on the storage depth).
  typedef struct packed {
    mem_op_e              op;
    logic [BLOCK_W-1:0]   wdata;
  } mem_req_t;
endpackage

// File: rtl/block_mem_array.sv
// block_mem_array: 2**IDX_W x 128-bit storage, synchronous write,
// registered read.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all lines
//                   and the read register)
//   we, widx, wdata write enable / index / block
//   re, ridx        read enable / index; rdata updates on the next edge
//   rdata           registered read block
module block_mem_array
  import mem_if_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [BLOCK_W-1:0] wdata,
  input  logic               re,
  input  logic [IDX_W-1:0]   ridx,
  output logic [BLOCK_W-1:0] rdata
);
  localparam int DEPTH = 2**IDX_W;

  logic [BLOCK_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[widx] <= wdata;
      if (re) rdata <= mem[ridx];
    end
  end
endmodule

// File: rtl/block_mem_responder.sv
// block_mem_responder: fixed-latency slow-memory model for the cache block
// interface. Accepts a held read/write request, answers LATENCY cycles
// after the request was first seen with a one-cycle mem_ready pulse.
// Ports:
//   clk, proc_reset      clock, synchronous active-high reset
//   mem_read, mem_write  held requests (dropped by the cache in the ready cycle)
//   mem_addr             block address; only [IDX_W-1:0] indexes storage
//   mem_wdata            write block
//   mem_rdata            read block, nonzero only in the ready cycle of a read
//   mem_ready            completion pulse
//   proto_err            sticky: request dropped while busy, or read+write
// Optional (`ifdef MEM_STATS_EN): stat_rd, stat_wr, stat_busy saturating
// counters of completed reads, completed writes, and BUSY/RESP cycles.
module block_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 6
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [BADDR_W-1:0] mem_addr,
  input  logic [BLOCK_W-1:0] mem_wdata,
  output logic [BLOCK_W-1:0] mem_rdata,
  output logic               mem_ready,
  output logic               proto_err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]        stat_rd,
  output logic [31:0]        stat_wr,
  output logic [31:0]        stat_busy
`endif
);
  logic [1:0]       state;
  logic [7:0]       cnt;
  mem_req_t         req;
  logic [IDX_W-1:0] req_idx;
  logic [BLOCK_W-1:0] rd_q;

  // Aliasing is intentional: upper address bits do not reach storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[BADDR_W-1:IDX_W];

  logic alive, accept, go_resp;
  assign alive   = mem_read | mem_write;
  assign accept  = (state == IDLE) && alive;
  // Entering RESP: straight from IDLE when LATENCY==1, else on the last
  // BUSY cycle with the request still held.
  assign go_resp = (accept && LATENCY == 1) ||
                   (state == BUSY && alive && cnt == 8'd1);

  // The read register is loaded on the edge into RESP; in the LATENCY==1
  // case the index still comes straight off the bus.
  block_mem_array #(.IDX_W(IDX_W)) u_arr (
    .clk   (clk),
    .rst   (proc_reset),
    .we    (state == RESP && req.op == OP_WR),
    .widx  (req_idx),
    .wdata (req.wdata),
    .re    (go_resp),
    .ridx  ((state == IDLE) ? mem_addr[IDX_W-1:0] : req_idx),
    .rdata (rd_q)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req       <= '0;
      req_idx   <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req.op    <= mem_write ? OP_WR : OP_RD;
          req.wdata <= mem_wdata;
          req_idx   <= mem_addr[IDX_W-1:0];
          cnt       <= 8'(LATENCY - 1);
          if (mem_read && mem_write) proto_err <= 1'b1;
          state     <= (LATENCY == 1) ? RESP : BUSY;
        end
        BUSY: begin
          if (!alive) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
            if (go_resp) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ready = (state == RESP);
  assign mem_rdata = (state == RESP && req.op == OP_RD) ? rd_q : '0;

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      stat_rd   <= '0;
      stat_wr   <= '0;
      stat_busy <= '0;
    end else begin
      if (state == RESP && req.op == OP_RD && stat_rd != '1) stat_rd <= stat_rd + 32'd1;
      if (state == RESP && req.op == OP_WR && stat_wr != '1) stat_wr <= stat_wr + 32'd1;
      if (state != IDLE && stat_busy != '1) stat_busy <= stat_busy + 32'd1;
    end
  end
`endif
endmodule

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
- Memory-side responder for the cache's 128-bit block interface. It answers block reads (Allocate) and block writes (WriteBack) after a fixed, programmable latency.
- Drives `mem_ready` as a one-cycle pulse and `mem_rdata` for the block.
- Sits between the data/instruction caches and backing storage. It is the standard slow-memory model for pipeline integration and cache verification.

Parameters:
- LATENCY, 8, cycles from request acceptance to the `mem_ready` pulse; legal range 1..255.
- IDX_W, 6, block index width; storage depth = 2**IDX_W lines of 128 bits.

Ports:
- clk  input  1  system clock, rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- mem_read  input  1  block read request; held by the cache until `mem_ready`.
- mem_write  input  1  block write request; held by the cache until `mem_ready`.
- mem_addr  input  28  block address (word address [29:2]).
- mem_wdata  input  128  write block; word 0 occupies bits [31:0].
- mem_rdata  output  128  read block; valid only while `mem_ready`=1, otherwise 0.
- mem_ready  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (`proc_reset`=1 at a clk edge):
  - state=IDLE; `mem_ready`=0, `mem_rdata`=0, `proto_err`=0; latency counter=0.
  - All storage lines cleared to 0.
  - Reset mid-transaction abandons it; no write is committed.
- Storage index = `mem_addr[IDX_W-1:0]`. Upper address bits are ignored, so addresses alias modulo depth.
- State IDLE:
  - If `mem_read` or `mem_write` is sampled high, latch op, addr and wdata.
  - Load counter = LATENCY-1 and go to BUSY.
  - If LATENCY=1, go directly to RESP instead.
- State BUSY:
  - Decrement the counter each cycle; when the counter reaches 0, go to RESP.
  - If the request drops (`mem_read`=`mem_write`=0), this is an abort: set `proto_err`, return to IDLE, commit nothing.
  - Request address/data changes while BUSY are ignored; the latched values are used.
- State RESP:
  - `mem_ready`=1 for exactly this cycle.
  - Read: `mem_rdata` = storage[latched idx], driven from a register loaded on the BUSY→RESP edge.
  - Write: storage[latched idx] <= latched wdata on the clock edge ending RESP.
  - Next state is always IDLE.
- Request sampling around RESP:
  - The cache deasserts its request combinationally in the `mem_ready` cycle, so requests in the RESP cycle are not sampled.
  - A request present in the following IDLE cycle starts a new transaction. This is the WriteBack→Allocate back-to-back case.
- Latency: request first high in cycle t ⇒ `mem_ready` high in cycle t+LATENCY.
- Simultaneous `mem_read`=`mem_write`=1 at acceptance: treat as a write and set `proto_err`.
- Read-after-write to the same index returns the new data, because the commit precedes the next acceptance.
- `proto_err` is cleared only by reset.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro `MEM_STATS_EN`.
- When defined, adds three outputs:
  - `stat_rd` [31:0]: count of completed reads.
  - `stat_wr` [31:0]: count of completed writes.
  - `stat_busy` [31:0]: count of cycles in BUSY or RESP.
- Counter behaviour:
  - Each counter increments on the RESP/BUSY condition above.
  - Counters saturate at 0xFFFFFFFF.
  - Counters clear on reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `mem_if_pkg`:
  - State encoding IDLE=2'b00, BUSY=2'b01, RESP=2'b10.
  - Widths: BLOCK_W=128, BADDR_W=28, WORD_W=32.
  - Op enum: OP_RD, OP_WR.
  - This package is shared with the cache's memory-side logic.
- One natural sub-module, `block_mem_array`:
  - Synchronous-write, registered-read 128-bit array.
  - Provides the reset clear and the index port.
  - The responder FSM instantiates it.

Test Plan:
- Reset, then block read at addr 0x0000005, LATENCY=8, storage clear ⇒ `mem_ready` pulses in cycle t+8 for exactly one cycle; `mem_rdata`=0; `proto_err`=0.
- Write 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D to addr 0x5; next IDLE cycle, read addr 0x5 ⇒ second `mem_ready` at t2+8 with that exact block.
- Alias check at IDX_W=6:
  - Write A to 0x0000003, then write B to 0x0000043.
  - Read 0x0000003 ⇒ returns B.
- Abort:
  - Write request dropped after 3 BUSY cycles ⇒ no `mem_ready`, `proto_err`=1.
  - A subsequent read of the same index returns the old data.
- `mem_read`=`mem_write`=1 at acceptance ⇒ write performed, `proto_err`=1. Then assert `proc_reset` in the middle of a following BUSY ⇒ outputs 0, no commit, state IDLE.
- LATENCY=1 with back-to-back requests ⇒ `mem_ready` on every other cycle. With `MEM_STATS_EN` defined, after 4 reads and 2 writes, `stat_rd`=4 and `stat_wr`=2.
